// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester (icache/dcache) line-transfer arbiter onto one memory port
// Grants whole BEATS-word lines; ties alternate using the last grant.
module mem_arb #(
  parameter int BEATS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ic_req,
  input  logic [31:0]              i_ic_addr,
  output logic                     o_ic_rvalid,
  output logic                     o_ic_done,
  input  logic                     i_dc_req,
  input  logic                     i_dc_we,
  input  logic [31:0]              i_dc_addr,
  input  logic [31:0]              i_dc_wdata,
  output logic                     o_dc_rvalid,
  output logic                     o_dc_done,
  output logic [31:0]              o_rdata,
  output logic [$clog2(BEATS)-1:0] o_beat,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [31:0]              o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic                     i_mem_ready,
  input  logic                     i_mem_rvalid,
  input  logic [31:0]              i_mem_rdata
);

  localparam int BW = $clog2(BEATS);
  localparam int CW = BW + 1;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nx;
  logic          last_gnt_d;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic [31:0]   base;
  logic          we;
  logic          accept, wr_mode, rd_active, rd_beat, last_rd, last_wr, done;

  assign o_mem_req = (state != IDLE) && (issue_cnt < CW'(BEATS));
  assign accept    = o_mem_req && i_mem_ready;
  assign wr_mode   = (state == GNT_D) && we;

  // Returns are only accepted while a read line is open and short of BEATS.
  assign rd_active = (state != IDLE) && !wr_mode && (ret_cnt < CW'(BEATS));
  assign rd_beat   = rd_active && i_mem_rvalid;
  assign last_rd   = rd_beat && (ret_cnt == CW'(BEATS - 1));
  assign last_wr   = wr_mode && accept && (issue_cnt == CW'(BEATS - 1));
  assign done      = last_rd || last_wr;

  assign o_mem_we    = wr_mode;
  assign o_mem_addr  = base + {{(32 - CW - 2){1'b0}}, issue_cnt, 2'b00};
  assign o_mem_wdata = i_dc_wdata;
  assign o_ic_rvalid = rd_beat && (state == GNT_I);
  assign o_dc_rvalid = rd_beat && (state == GNT_D);
  assign o_ic_done   = done && (state == GNT_I);
  assign o_dc_done   = done && (state == GNT_D);
  assign o_rdata     = rd_beat ? i_mem_rdata : 32'd0;
  assign o_beat      = wr_mode ? issue_cnt[BW-1:0] : ret_cnt[BW-1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_ic_req && i_dc_req) state_nx = last_gnt_d ? GNT_I : GNT_D;
        else if (i_dc_req)        state_nx = GNT_D;
        else if (i_ic_req)        state_nx = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_gnt_d <= 1'b0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      base       <= 32'd0;
      we         <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        if (state_nx == GNT_I) begin
          base       <= {i_ic_addr[31:BW+2], {(BW + 2){1'b0}}};
          we         <= 1'b0;
          last_gnt_d <= 1'b0;
        end else if (state_nx == GNT_D) begin
          base       <= {i_dc_addr[31:BW+2], {(BW + 2){1'b0}}};
          we         <= i_dc_we;
          last_gnt_d <= 1'b1;
        end
      end else if (done) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (accept)  issue_cnt <= issue_cnt + 1'b1;
        if (rd_beat) ret_cnt   <= ret_cnt + 1'b1;
      end
    end
  end

  spurious_rvalid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    i_mem_rvalid |-> rd_active)
    else $warning("mem_arb: i_mem_rvalid with no read outstanding, ignored");

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_mem_arb;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ic_req = 1'b0, i_dc_req = 1'b0, i_dc_we = 1'b0;
  logic [31:0] i_ic_addr = 32'd0, i_dc_addr = 32'd0, i_dc_wdata;
  logic        o_ic_rvalid, o_ic_done, o_dc_rvalid, o_dc_done;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_beat;
  logic        o_mem_req, o_mem_we;
  logic        i_mem_ready = 1'b1, i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  mem_arb #(.BEATS(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr),
    .o_ic_rvalid(o_ic_rvalid), .o_ic_done(o_ic_done),
    .i_dc_req(i_dc_req), .i_dc_we(i_dc_we), .i_dc_addr(i_dc_addr), .i_dc_wdata(i_dc_wdata),
    .o_dc_rvalid(o_dc_rvalid), .o_dc_done(o_dc_done),
    .o_rdata(o_rdata), .o_beat(o_beat),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  assign i_dc_wdata = 32'hD000_0000 | {30'd0, o_beat};

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  beat;
    logic        done;
  } acc_t;
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  beat;
    logic        done;
  } rv_t;

  acc_t acc_q[$];
  rv_t  ic_q[$], dc_q[$];
  bit   rdy_q[$];
  int   errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  task automatic push_fill(input bit to_d, input logic [31:0] base, input int n_rv);
    for (int i = 0; i < 4; i++) begin
      acc_q.push_back('{base + 32'(4 * i), 1'b0, 32'h0, 2'(i), 1'b0});
      if (i < n_rv) begin
        if (to_d) dc_q.push_back('{~(base + 32'(4 * i)), 2'(i), 1'(i == 3)});
        else      ic_q.push_back('{~(base + 32'(4 * i)), 2'(i), 1'(i == 3)});
      end
    end
  endtask

  task automatic push_write(input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      acc_q.push_back('{base + 32'(4 * i), 1'b1, 32'hD000_0000 + 32'(i), 2'(i), 1'(i == 3)});
  endtask

  task automatic wait_done(input bit d, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge i_clk);
      seen = d ? o_dc_done : o_ic_done;
    end
    check(name, {31'd0, seen}, 32'd1);
    @(posedge i_clk); #1;
  endtask

  // Memory model: read data is ~addr, returned two cycles after acceptance.
  logic        acc_v = 1'b0, p0_v = 1'b0;
  logic [31:0] acc_a = 32'd0, p0_a = 32'd0;
  bit          spur = 1'b0, spur_now = 1'b0;

  always @(negedge i_clk) begin
    if (o_mem_req && i_mem_ready && !o_mem_we) begin
      acc_v = 1'b1;
      acc_a = o_mem_addr;
    end
  end

  always @(posedge i_clk) begin
    #1;
    spur_now = 1'b0;
    if (spur) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hDEAD_BEEF;
      spur         = 1'b0;
      spur_now     = 1'b1;
    end else begin
      i_mem_rvalid = p0_v;
      i_mem_rdata  = p0_v ? ~p0_a : 32'd0;
    end
    p0_v  = acc_v;
    p0_a  = acc_a;
    acc_v = 1'b0;
    if (o_mem_req && rdy_q.size() != 0) i_mem_ready = rdy_q.pop_front();
    else                                i_mem_ready = 1'b1;
  end

  acc_t a;
  rv_t  r;
  logic exp_i, exp_d;

  always @(negedge i_clk) begin
    exp_i = 1'b0;
    exp_d = 1'b0;
    if (o_ic_rvalid && o_dc_rvalid) unexpected("rvalid_both", 32'd1);
    if (spur_now) check("spur_ignored", {31'd0, o_ic_rvalid | o_dc_rvalid}, 32'd0);
    if (o_mem_req && i_mem_ready) begin
      if (acc_q.size() == 0) unexpected("mem_accept", o_mem_addr);
      else begin
        a = acc_q.pop_front();
        check("mem_addr", o_mem_addr, a.addr);
        check("mem_we", {31'd0, o_mem_we}, {31'd0, a.we});
        if (a.we) begin
          check("wr_beat", {30'd0, o_beat}, {30'd0, a.beat});
          check("mem_wdata", o_mem_wdata, a.wdata);
          exp_d = exp_d | a.done;
        end
      end
    end
    if (o_ic_rvalid) begin
      if (ic_q.size() == 0) unexpected("ic_rvalid", o_rdata);
      else begin
        r = ic_q.pop_front();
        check("ic_rdata", o_rdata, r.rdata);
        check("ic_beat", {30'd0, o_beat}, {30'd0, r.beat});
        exp_i = r.done;
      end
    end
    if (o_dc_rvalid) begin
      if (dc_q.size() == 0) unexpected("dc_rvalid", o_rdata);
      else begin
        r = dc_q.pop_front();
        check("dc_rdata", o_rdata, r.rdata);
        check("dc_beat", {30'd0, o_beat}, {30'd0, r.beat});
        exp_d = exp_d | r.done;
      end
    end
    if (o_ic_done || exp_i) check("ic_done", {31'd0, o_ic_done}, {31'd0, exp_i});
    if (o_dc_done || exp_d) check("dc_done", {31'd0, o_dc_done}, {31'd0, exp_d});
  end

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, {31'd0, o_mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, o_mem_we}, 32'd0);
    check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
    check({tag, "_ic_rvalid"}, {31'd0, o_ic_rvalid}, 32'd0);
    check({tag, "_dc_rvalid"}, {31'd0, o_dc_rvalid}, 32'd0);
    check({tag, "_ic_done"}, {31'd0, o_ic_done}, 32'd0);
    check({tag, "_dc_done"}, {31'd0, o_dc_done}, 32'd0);
    check({tag, "_beat"}, {30'd0, o_beat}, 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check_quiet("reset");
    @(posedge i_clk); #1;

    // First tie after reset goes to D, then the waiting I is served.
    push_fill(1'b1, 32'h0000_2000, 4);
    push_fill(1'b0, 32'h0000_3000, 4);
    i_dc_addr = 32'h0000_2000; i_dc_we = 1'b0; i_ic_addr = 32'h0000_3000;
    i_dc_req = 1'b1; i_ic_req = 1'b1;
    fork
      begin wait_done(1'b1, "tie1_d_wait"); i_dc_req = 1'b0; end
      begin wait_done(1'b0, "tie1_i_wait"); i_ic_req = 1'b0; end
    join

    // Last grant was I, so the next tie goes to D again.
    push_fill(1'b1, 32'h0000_2100, 4);
    push_fill(1'b0, 32'h0000_3100, 4);
    i_dc_addr = 32'h0000_2104; i_ic_addr = 32'h0000_3108;
    i_dc_req = 1'b1; i_ic_req = 1'b1;
    fork
      begin wait_done(1'b1, "tie2_d_wait"); i_dc_req = 1'b0; end
      begin wait_done(1'b0, "tie2_i_wait"); i_ic_req = 1'b0; end
    join

    // I-only fill, unaligned miss address.
    push_fill(1'b0, 32'h0000_1230, 4);
    i_ic_addr = 32'h0000_1234; i_ic_req = 1'b1;
    wait_done(1'b0, "ifill_wait"); i_ic_req = 1'b0;

    // D write-back with stalls; a stray rvalid mid-write must be dropped.
    rdy_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    push_write(32'h8000_0010);
    i_dc_addr = 32'h8000_0010; i_dc_we = 1'b1; i_dc_req = 1'b1;
    fork
      wait_done(1'b1, "wb_wait");
      begin repeat (3) @(posedge i_clk); #2 spur = 1'b1; end
    join
    i_dc_req = 1'b0; i_dc_we = 1'b0;
    check("wb_ready_used", rdy_q.size(), 32'd0);

    // Top-of-memory line: no carry out of the line.
    push_fill(1'b0, 32'hFFFF_FFF0, 4);
    i_ic_addr = 32'hFFFF_FFF4; i_ic_req = 1'b1;
    wait_done(1'b0, "top_wait"); i_ic_req = 1'b0;

    // Reset after two returned beats: four accepts, two beats, no done.
    push_fill(1'b0, 32'h0000_4000, 2);
    i_ic_addr = 32'h0000_4008; i_ic_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge i_clk);
      if (o_ic_rvalid && o_beat == 2'd1) found = 1'b1;
    end
    check("rst_wait", {31'd0, found}, 32'd1);
    #1 i_rst_n = 1'b0; i_ic_req = 1'b0;
    @(negedge i_clk);
    check_quiet("midrst");
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    push_fill(1'b0, 32'h0000_5000, 4);
    i_ic_addr = 32'h0000_500C; i_ic_req = 1'b1;
    wait_done(1'b0, "post_rst_wait"); i_ic_req = 1'b0;

    // Stray rvalid while idle.
    repeat (2) @(posedge i_clk);
    #2 spur = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;

    // Requester drops req and changes inputs mid-fill; latched line still completes.
    push_fill(1'b1, 32'h0000_6000, 4);
    i_dc_addr = 32'h0000_6004; i_dc_we = 1'b0; i_dc_req = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_dc_req = 1'b0; i_dc_addr = 32'h0000_7000; i_dc_we = 1'b1;
    wait_done(1'b1, "drop_wait");

    repeat (5) @(posedge i_clk);
    #1;
    check("acc_q_left", acc_q.size(), 32'd0);
    check("ic_q_left", ic_q.size(), 32'd0);
    check("dc_q_left", dc_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning words per line transfer (power of 2, 2..16).
REQ-002 SHALL have port i_clk  input  1  global clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  global reset, synchronous, active-low.
REQ-004 SHALL have port i_ic_req  input  1  instruction-cache line-fill request, held until o_ic_done.
REQ-005 SHALL have port i_ic_addr  input  32  instruction-cache miss address.
REQ-006 SHALL have port o_ic_rvalid  output  1  read beat valid to instruction cache.
REQ-007 SHALL have port o_ic_done  output  1  one-cycle pulse, instruction transaction complete.
REQ-008 SHALL have port i_dc_req  input  1  data-cache request, held until o_dc_done.
REQ-009 SHALL have port i_dc_we  input  1  1 = line write-back, 0 = line fill.
REQ-010 SHALL have port i_dc_addr  input  32  data-cache line address.
REQ-011 SHALL have port i_dc_wdata  input  32  write data for the beat indexed by o_beat.
REQ-012 SHALL have port o_dc_rvalid  output  1  read beat valid to data cache.
REQ-013 SHALL have port o_dc_done  output  1  one-cycle pulse, data transaction complete.
REQ-014 SHALL have port o_rdata  output  32  shared read data, valid with o_ic_rvalid/o_dc_rvalid.
REQ-015 SHALL have port o_beat  output  log2(BEATS)  beat index: issue count during writes, return count during reads.
REQ-016 SHALL have port o_mem_req, o_mem_we (1), o_mem_addr, o_mem_wdata (32)  outputs  single backing-memory port.
REQ-017 SHALL have port i_mem_ready  input  1  memory accepts beat when o_mem_req & i_mem_ready.
REQ-018 SHALL have port i_mem_rvalid, i_mem_rdata (1, 32)  inputs  in-order read return.

Function
REQ-019 SHALL implement FSM states IDLE, GNT_I, GNT_D; arbitration occurs only in IDLE.
REQ-020 In IDLE, single requester SHALL be granted next cycle; both pending SHALL grant the requester not granted last (last_gnt reg, reset value I, so first tie goes to D).
REQ-021 On grant SHALL latch line base = addr with low log2(BEATS)+2 bits cleared, and latch i_dc_we; later input changes ignored.
REQ-022 In grant state SHALL assert o_mem_req while issue_cnt < BEATS; o_mem_addr = base + 4*issue_cnt; issue_cnt increments on each accepted beat.
REQ-023 o_mem_we SHALL equal latched we in GNT_D, 0 in GNT_I; o_mem_wdata SHALL equal i_dc_wdata combinationally.
REQ-024 Reads: each i_mem_rvalid SHALL be forwarded same cycle to the granted requester's rvalid with o_rdata = i_mem_rdata; ret_cnt increments.
REQ-025 Read done SHALL pulse same cycle as the BEATS-th rvalid; write done SHALL pulse same cycle as the BEATS-th accepted beat.
REQ-026 FSM SHALL return to IDLE the cycle after done; minimum one IDLE cycle between transactions.
REQ-027 Request deassertion mid-transaction SHALL be ignored; transaction runs to completion.
REQ-028 i_mem_rvalid in IDLE or during a write SHALL be ignored (no rvalid out); simulation assertion flags it.
REQ-029 Counters SHALL be log2(BEATS)+1 bits; no wrap; address addition modulo 2^32.
REQ-030 o_mem_req SHALL never assert in IDLE; o_ic_* and o_dc_* rvalid/done SHALL be mutually exclusive.

Reset
REQ-031 On i_rst_n=0 at clock edge: state IDLE, counters 0, last_gnt=I, base 0; all outputs 0 from next cycle.
REQ-032 Reset mid-transaction SHALL abort with no done pulse; late rvalids after reset ignored per REQ-028.

Verification
REQ-033 I-only fill, addr 0x0000_1234, ready=1, rvalid 2 cycles after accept -> mem addrs 0x1230,0x1234,0x1238,0x123C; 4 o_ic_rvalid; o_ic_done on 4th.
REQ-034 Both req same cycle after reset -> D granted first; then I granted; next tie -> D (alternation).
REQ-035 D write-back 0x8000_0010, ready toggling 1,0,1,1,0,1 -> o_beat 0..3 in order, o_mem_we=1, o_dc_done with 4th accept, no rvalid out.
REQ-036 Address 0xFFFF_FFF4 fill -> addrs 0xFFFF_FFF0..0xFFFF_FFFC, no carry corruption.
REQ-037 Reset asserted after 2 of 4 read beats -> no done, IDLE, outputs 0; fresh I request completes normally.
REQ-038 Spurious rvalid in IDLE and requester dropping req mid-fill -> no output rvalid / transaction still completes with done.
